// File: rtl/eda_seq_pkg.sv
// eda_seq_pkg: state encoding and build defaults for the frame sequencer.
// CFG_* defaults apply only when the build does not set them.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif

package eda_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    RUN,
    DRAIN
  } seq_state_t;

  localparam int M_DEF           = `CFG_M;
  localparam int N_DEF           = `CFG_N;
  localparam int ADDR_WIDTH_DEF  = `CFG_ADDR_WIDTH;
  localparam int PIXEL_WIDTH_DEF = `CFG_PIXEL_WIDTH;
  localparam int RD_LATENCY_DEF  = 1;

  localparam int FRAME_SZ   = M_DEF * N_DEF;
  localparam int SKID_DEPTH = RD_LATENCY_DEF + 1;

  function automatic int skid_depth(input int lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/eda_seq_skid_fifo.sv
// eda_seq_skid_fifo: small result FIFO (data bit + last flag).
// free reports room left once this cycle's pop is taken.
module eda_seq_skid_fifo
  import eda_seq_pkg::*;
#(
  parameter int DEPTH = SKID_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         push_data,
  input  logic                         push_last,
  input  logic                         ready,
  output logic                         valid,
  output logic                         data,
  output logic                         last,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_n;
  logic [PW-1:0] rp_n;
  logic [CW-1:0] cnt;
  logic          pop;

  assign valid = (cnt != '0);
  assign pop   = valid & ready;
  assign data  = valid & mem[rp][0];
  assign last  = valid & mem[rp][1];
  assign free  = CW'(DEPTH) - cnt + CW'(pop);

  always_comb begin
    wp_n = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
    rp_n = (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= {push_last, push_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else if (flush) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else begin
      if (push) begin
        wp <= wp_n;
      end
      if (pop) begin
        rp <= rp_n;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/eda_frame_sequencer.sv
// eda_frame_sequencer: loads a frame, kicks the controller, streams results.
// EDA_SEQ_TIMEOUT_EN adds a RUN watchdog with a sticky timeout_err.
module eda_frame_sequencer
  import eda_seq_pkg::*;
#(
  parameter int M           = M_DEF,
  parameter int N           = N_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int RD_LATENCY  = RD_LATENCY_DEF
`ifdef EDA_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_WIDTH   = 20
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   abort,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  output logic                   write_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   start,
  input  logic                   done,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   matrix_output,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int DEPTH = skid_depth(RD_LATENCY);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(M * N - 1);

  seq_state_t state;
  seq_state_t nxt;

  logic [ADDR_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH-1:0] rcnt;
  logic                  rd_done;
  logic                  wait_low;
  logic [RD_LATENCY-1:0] pv;
  logic [RD_LATENCY-1:0] pl;
  logic [CW-1:0]         free;
  logic [CW-1:0]         inflight;
  logic                  beat;
  logic                  issue;
  logic                  last_fire;
  logic                  tmo_hit;

  assign s_ready   = ~abort & (((state == IDLE) & ~wait_low) | (state == LOAD));
  assign beat      = s_valid & s_ready;
  assign write_en  = beat;
  assign wr_addr   = wcnt;
  assign pixel_in  = beat ? s_pixel : '0;
  assign start     = (state == KICK) & ~abort;
  assign busy      = (state != IDLE);
  assign rd_addr   = rcnt;
  assign last_fire = m_valid & m_ready & m_last;

  // Reads still in the RAM pipeline will land in the FIFO later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pv[i]);
    end
  end

  assign issue = (state == DRAIN) & ~rd_done & ~abort & (free > inflight);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (beat) nxt = (wcnt == LAST) ? KICK : LOAD;
      LOAD:    if (beat && wcnt == LAST) nxt = KICK;
      KICK:    nxt = RUN;
      RUN:     if (done) nxt = DRAIN;
      DRAIN:   if (last_fire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort || tmo_hit) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt       <= '0;
      rcnt       <= '0;
      rd_done    <= 1'b0;
      pv         <= '0;
      pl         <= '0;
      frame_done <= 1'b0;
    end else if (abort || tmo_hit) begin
      wcnt       <= '0;
      rcnt       <= '0;
      rd_done    <= 1'b0;
      pv         <= '0;
      pl         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_fire;
      pv <= (pv << 1) | RD_LATENCY'(issue);
      pl <= (pl << 1) | RD_LATENCY'(issue & (rcnt == LAST));
      if (beat) begin
        wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
      end
      if (last_fire) begin
        rcnt    <= '0;
        rd_done <= 1'b0;
      end else if (issue) begin
        if (rcnt == LAST) begin
          rd_done <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

  // Controller may still be running: hold off the next frame until done drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_low <= 1'b1;
    end else if ((abort && state == RUN) || tmo_hit) begin
      wait_low <= 1'b1;
    end else if (!done) begin
      wait_low <= 1'b0;
    end
  end

  eda_seq_skid_fifo #(
    .DEPTH(DEPTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort | tmo_hit),
    .push     (pv[RD_LATENCY-1]),
    .push_data(matrix_output),
    .push_last(pl[RD_LATENCY-1]),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .last     (m_last),
    .free     (free)
  );

`ifdef EDA_SEQ_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo;
  logic                 tmo_err;

  assign tmo_hit     = (state == RUN) & (&tmo) & ~abort;
  assign timeout_err = tmo_err;

  // Counting starts in KICK so the flag lands 2^W-1 cycles into RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo     <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (abort) begin
        tmo_err <= 1'b0;
      end else if (tmo_hit) begin
        tmo_err <= 1'b1;
      end
      if (!abort && (state == KICK || state == RUN)) begin
        tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_eda_frame_sequencer.sv
// tb_eda_frame_sequencer: directed frames from a vector table plus
// hand-written abort and mid-drain reset sequences (M=N=4, RD_LATENCY=1).
module tb_eda_frame_sequencer;
  import eda_seq_pkg::*;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int FS = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_pixel = '0;
  logic          write_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pixel_in;
  logic          start;
  logic          done = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          matrix_output = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_data;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  always #5 clk = ~clk;

  eda_frame_sequencer #(
    .M(4), .N(4), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
    .start(start), .done(done), .rd_addr(rd_addr),
    .matrix_output(matrix_output),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  // Image RAM model; the result bit is the parity of the stored pixel.
  logic [PW-1:0] ram [FS];
  always @(posedge clk) matrix_output <= ^ram[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr, first_wr, last_wr, n_start, start_cyc;
  int n_beat, first_beat, last_beat, n_fd, fd_cyc, n_mv;
  logic [AW-1:0] wlog_addr [FS];
  logic [PW-1:0] wlog_pix [FS];
  logic          bdata [64];
  logic          blast [64];
  logic [PW-1:0] pix [FS];

  always @(negedge clk) begin
    if (write_en) begin
      ram[wr_addr] = pixel_in;
      if (n_wr < FS) begin
        wlog_addr[n_wr] = wr_addr;
        wlog_pix[n_wr]  = pixel_in;
      end
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
    end
    if (start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (m_valid) n_mv++;
    if (m_valid && m_ready) begin
      if (n_beat < 64) begin
        bdata[n_beat] = m_data;
        blast[n_beat] = m_last;
      end
      if (n_beat == 0) first_beat = cyc;
      last_beat = cyc;
      n_beat++;
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_wr = 0; first_wr = 0; last_wr = 0; n_start = 0; start_cyc = 0;
    n_beat = 0; first_beat = 0; last_beat = 0; n_fd = 0; fd_cyc = 0;
    n_mv = 0;
  endtask

  task automatic set_pix(input logic [7:0] seed);
    for (int i = 0; i < FS; i++) pix[i] = seed + 8'(i * 37);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_px(input bit gap, input int cnt);
    int idx = 0;
    int k = 0;
    while (idx < cnt && k < 200) begin
      s_valid = gap ? ((k % 2) == 0) : 1'b1;
      s_pixel = pix[idx];
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      tick();
      k++;
    end
    s_valid = 1'b0;
    chk("load_beats", idx, cnt);
  endtask

  task automatic chk_writes(input string tag);
    int bad_a = 0;
    int bad_p = 0;
    for (int i = 0; i < FS; i++) begin
      if (wlog_addr[i] != AW'(i)) bad_a++;
      if (wlog_pix[i] != pix[i]) bad_p++;
    end
    chk({tag, "_n_writes"}, n_wr, FS);
    chk({tag, "_wr_addr_seq"}, bad_a, 0);
    chk({tag, "_wr_data"}, bad_p, 0);
  endtask

  task automatic drain(input bit stall);
    int k = 0;
    while (n_fd == 0 && k < 300) begin
      m_ready = stall ? ((k % 7) < 4) : 1'b1;
      tick();
      k++;
    end
    m_ready = 1'b0;
    chk("drain_finished", int'(n_fd > 0), 1);
  endtask

  typedef struct {
    bit         gap;
    bit         stall;
    int         run_cyc;
    logic [7:0] seed;
    int         exp_wr_span;
    int         exp_beat_span;
  } fvec_t;

  fvec_t tbl [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad_d;
    int bad_l;
    tbl[0] = '{1'b0, 1'b0, 50, 8'h11, 15, 15};
    tbl[1] = '{1'b1, 1'b0, 10, 8'h5a, 30, 15};
    tbl[2] = '{1'b0, 1'b1,  3, 8'hc3, 15, -1};
    clr_mon();

    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_start", start, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_addrs", int'({wr_addr, rd_addr}), 0);
    chk("rst_pixel_in", pixel_in, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_s_ready", s_ready, 1);

    for (int t = 0; t < 3; t++) begin
      clr_mon();
      set_pix(tbl[t].seed);
      load_px(tbl[t].gap, FS);
      chk_writes("frame");
      chk("wr_span", last_wr - first_wr, tbl[t].exp_wr_span);
      repeat (tbl[t].run_cyc) tick();
      chk("start_once", n_start, 1);
      chk("start_after_last_wr", start_cyc - last_wr, 1);
      chk("run_busy", busy, 1);
      chk("run_no_m_valid", n_mv, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      drain(tbl[t].stall);
      bad_d = 0;
      bad_l = 0;
      for (int i = 0; i < FS; i++) begin
        if (bdata[i] !== ^pix[i]) bad_d++;
        if (blast[i] !== (i == FS - 1)) bad_l++;
      end
      chk("n_beats", n_beat, FS);
      chk("beat_data", bad_d, 0);
      chk("beat_last", bad_l, 0);
      chk("frame_done_once", n_fd, 1);
      chk("frame_done_lag", fd_cyc - last_beat, 1);
      if (tbl[t].exp_beat_span >= 0)
        chk("beat_span", last_beat - first_beat, tbl[t].exp_beat_span);
      tick();
      chk("post_idle", busy, 0);
    end

    // Abort in LOAD at wcnt=7, then a full frame from address 0.
    clr_mon();
    set_pix(8'h3c);
    load_px(1'b0, 7);
    s_valid = 1'b1;
    s_pixel = pix[7];
    abort = 1'b1;
    @(negedge clk);
    chk("abort_no_write", write_en, 0);
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("abort_idle", busy, 0);
    repeat (3) tick();
    chk("abort_no_start", n_start, 0);
    clr_mon();
    load_px(1'b0, FS);
    chk_writes("after_abort");
    tick();
    chk("after_abort_start", n_start, 1);

    // Abort in RUN with done held: next load waits for done low.
    done = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("run_abort_idle", busy, 0);
    tick();
    chk("wait_done_low", s_ready, 0);
    chk("run_abort_no_m_valid", n_mv, 0);
    done = 1'b0;
    tick();
    chk("done_low_ready", s_ready, 1);

    // Reset while results sit in the FIFO under backpressure.
    clr_mon();
    set_pix(8'h77);
    load_px(1'b0, FS);
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (6) tick();
    chk("stalled_m_valid", m_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_addr", rd_addr, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst_ready", s_ready, 1);
    chk("arst_m_valid_after", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
